hilo_div_unit: RTL and testbench

Iterative multi-cycle divider that produces the HI/LO write for DIV/DIVU in the EX stage. It takes two 32-bit operands on a start pulse, runs a radix-2 restoring division over 32 cycles, and drives a one-cycle write strobe with remainder (HI) and quotient (LO). It feeds the write port of the HI/LO register. The pipeline stalls on `busy_o` until the write strobe is issued.

---
 rtl/hilo_div_unit.sv | 175 +++++++++++++++++
 tb/tb_hilo_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// hilo_div_unit
//
// Iterative radix-2 restoring divider that produces the HI/LO register write
// for DIV/DIVU. Operands are latched on a start pulse in IDLE, 32 iterations
// run in ON, and END drives a single-cycle write strobe carrying the remainder
// on hi_o and the quotient on lo_o.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   start_i     request a division (sampled only in IDLE)
//   signed_i    1 = DIV (two's complement), 0 = DIVU
//   annul_i     cancel a pending or in-flight operation
//   opdata1_i   dividend
//   opdata2_i   divisor
//   busy_o      high whenever the unit is not IDLE
//   hilo_we_o   one-cycle write strobe to HI/LO
//   hi_o        remainder, zero unless hilo_we_o
//   lo_o        quotient, zero unless hilo_we_o
//   div_zero_o  divisor was zero, qualified by hilo_we_o

module hilo_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    output logic             busy_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StEnd
    } state_e;

    state_e            state_q, state_d;
    // Holds the (absolute) dividend; quotient bits shift in from the right.
    logic [WIDTH-1:0]  dividend_q, dividend_d;
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              quot_neg_q, quot_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              div_zero_q, div_zero_d;

    // Operand magnitudes for the signed case.
    logic              op1_neg, op2_neg;
    logic [WIDTH-1:0]  op1_abs, op2_abs;

    assign op1_neg = signed_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_i & opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step. The full remainder is shifted into a WIDTH+1 bit
    // value so divisors with the MSB set cannot lose the remainder's top bit.
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    trial;
    logic              last_iter;

    assign shifted   = {rem_q, dividend_q[WIDTH-1]};
    assign trial     = shifted - {1'b0, divisor_q};
    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;

        busy_o     = (state_q != StIdle);
        hilo_we_o  = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        div_zero_o = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i && !annul_i) begin
                    cnt_d = '0;
                    if (opdata2_i == '0) begin
                        // Reuse the END output path: quotient all ones,
                        // remainder is the raw dividend, no sign fix-up.
                        dividend_d = '1;
                        divisor_d  = '0;
                        rem_d      = opdata1_i;
                        quot_neg_d = 1'b0;
                        rem_neg_d  = 1'b0;
                        div_zero_d = 1'b1;
                        state_d    = StEnd;
                    end else begin
                        dividend_d = op1_abs;
                        divisor_d  = op2_abs;
                        rem_d      = '0;
                        quot_neg_d = op1_neg ^ op2_neg;
                        rem_neg_d  = op1_neg;
                        div_zero_d = 1'b0;
                        state_d    = StOn;
                    end
                end
            end

            StOn: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_d      = trial[WIDTH-1:0];
                        dividend_d = {dividend_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d      = shifted[WIDTH-1:0];
                        dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (last_iter) begin
                        state_d = StEnd;
                    end
                end
            end

            StEnd: begin
                state_d = StIdle;
                // Annul in END kills the strobe in the same cycle.
                if (!annul_i) begin
                    hilo_we_o  = 1'b1;
                    lo_o       = quot_neg_q ? (~dividend_q + 1'b1) : dividend_q;
                    hi_o       = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
                    div_zero_o = div_zero_q;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
module tb_hilo_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic        annul;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;

    int n_vec = 0;
    int n_err = 0;

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .signed_i   (sgn),
        .annul_i    (annul),
        .opdata1_i  (op1),
        .opdata2_i  (op2),
        .busy_o     (busy),
        .hilo_we_o  (we),
        .hi_o       (hi),
        .lo_o       (lo),
        .div_zero_o (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: returns {div_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        int sa, sb, q, r;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (!s) return {1'b0, a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk);
        #1;
        op1   = a;
        op2   = b;
        sgn   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycle c counts from the start edge; checks cycles first..last.
    task automatic watch(input int first, input int last, input int lat,
                         input logic [64:0] exp, input string tag);
        for (int c = first; c <= last; c++) begin
            @(negedge clk);
            check({tag, "_busy"}, 96'(busy), 96'(c <= lat));
            check({tag, "_we"}, 96'(we), 96'(c == lat));
            if (c == lat) check({tag, "_res"}, 96'({dz, hi, lo}), 96'(exp));
            else check({tag, "_quiet"}, 96'({dz, hi, lo}), 96'd0);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input string tag);
        int lat;
        lat = (b == 32'd0) ? 1 : 33;
        launch(a, b, s);
        watch(1, lat + 1, lat, ref_div(a, b, s), tag);
    endtask

    task automatic no_strobe(input int cycles, input string tag);
        int pulses;
        int busy_cnt;
        pulses = 0;
        busy_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (we) pulses++;
            if (busy) busy_cnt++;
        end
        check({tag, "_pulses"}, 96'(pulses), 96'd0);
        check({tag, "_busy"}, 96'(busy_cnt), 96'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic s;
        rst   = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        annul = 1'b0;
        op1   = '0;
        op2   = '0;
        #12;
        check("reset", 96'({busy, we, dz, hi, lo}), 96'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        do_op(32'd100, 32'd7, 1'b0, "u100_7");
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, "s_7_m2");
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
        do_op(32'h0000_1234, 32'd0, 1'b0, "dz");
        do_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "u_bigdiv");
        do_op(32'h8000_0000, 32'd0, 1'b1, "dz_signed");

        // Annul at iteration 10, then a fresh 9/3
        launch(32'd100, 32'd7, 1'b0);
        watch(1, 10, 33, 65'd0, "ann_pre");
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        no_strobe(40, "ann_post");
        do_op(32'd9, 32'd3, 1'b0, "after_ann");

        // Annul in END suppresses the strobe
        launch(32'd5, 32'd0, 1'b0);
        annul = 1'b1;
        @(negedge clk);
        check("ann_end_we", 96'({we, dz, hi, lo}), 96'd0);
        check("ann_end_busy", 96'(busy), 96'd1);
        @(posedge clk);
        #1;
        annul = 1'b0;
        no_strobe(5, "ann_end_post");

        // Annul together with start in IDLE: start ignored
        @(posedge clk);
        #1;
        op1 = 32'd50;
        op2 = 32'd5;
        start = 1'b1;
        annul = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        no_strobe(40, "ann_start");

        // Restart during ON is ignored
        launch(32'd100, 32'd7, 1'b0);
        watch(1, 4, 33, ref_div(32'd100, 32'd7, 1'b0), "rst_ign_a");
        @(posedge clk);
        #1;
        op1 = 32'd50;
        op2 = 32'd3;
        sgn = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        watch(6, 34, 33, ref_div(32'd100, 32'd7, 1'b0), "rst_ign_b");

        // Asynchronous reset mid-operation
        launch(32'd100, 32'd7, 1'b0);
        watch(1, 20, 33, 65'd0, "mid_rst_pre");
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out", 96'({busy, we, dz, hi, lo}), 96'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        no_strobe(40, "mid_rst_post");
        do_op(32'd1000, 32'd10, 1'b0, "mid_rst_next");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'd0 - $urandom_range(1, 15);
                3: b = 32'h8000_0000 | $urandom;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
            s = 1'($urandom_range(0, 1));
            do_op(a, b, s, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
